// File: rtl/qar_timer_pkg.sv
// Shared constants for the qar timer peripheral: register word offsets,
// CTRL/STATUS bit positions and the default watchdog kick key.
package qar_timer_pkg;

    localparam logic [7:0] OFF_CTRL       = 8'd0;
    localparam logic [7:0] OFF_STATUS     = 8'd1;
    localparam logic [7:0] OFF_PRESCALE   = 8'd2;
    localparam logic [7:0] OFF_COUNT      = 8'd3;
    localparam logic [7:0] OFF_COMPARE    = 8'd4;
    localparam logic [7:0] OFF_WDT_LOAD   = 8'd5;
    localparam logic [7:0] OFF_WDT_KICK   = 8'd6;
    localparam logic [7:0] OFF_CAPTURE    = 8'd7;
    localparam logic [7:0] OFF_PWM_PERIOD = 8'd8;
    localparam logic [7:0] OFF_PWM_DUTY   = 8'd9;

    localparam int unsigned CTRL_TMR_EN = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_WDT_EN = 2;
    localparam int unsigned CTRL_PWM_EN = 3;
    localparam int unsigned CTRL_CAP_EN = 4;
    localparam int unsigned CTRL_W      = 5;

    localparam int unsigned ST_MATCH     = 0;
    localparam int unsigned ST_CAP_VALID = 1;
    localparam int unsigned ST_WDT_EXP   = 2;
    localparam int unsigned ST_CAP_OVR   = 3;
    localparam int unsigned ST_PWM_WRAP  = 4;
    localparam int unsigned ST_W         = 5;

    localparam logic [31:0] WDT_KEY_DEFAULT = 32'h0000_5A5A;

endpackage

// File: rtl/qar_timer_periph_if.sv
// qar_core data-bus slice seen by the timer peripheral (core is master).
interface qar_timer_periph_if #(
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  bus_valid;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [31:0]           bus_wdata;
    logic                  bus_ready;
    logic [31:0]           bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/qar_pwm_gen.sv
// PWM generator: free-running 0..PERIOD-1 counter with PERIOD/DUTY shadowed
// so new settings only take effect at a period boundary.
module qar_pwm_gen #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] duty,
    output logic                 pwm_out,
    output logic                 wrap
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] period_sh;
    logic [CNT_WIDTH-1:0] duty_sh;
    logic                 at_end;

    assign at_end  = (period_sh != '0) && (cnt == period_sh - CNT_WIDTH'(1));
    assign wrap    = en & at_end;
    assign pwm_out = en & (period_sh != '0) & (cnt < duty_sh);

    // Counter and shadow registers; a zero shadow period keeps tracking the
    // live registers so a later non-zero PERIOD is not stuck behind a wrap
    // that can never happen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            period_sh <= '0;
            duty_sh   <= '0;
        end else if (!en || (period_sh == '0)) begin
            cnt       <= '0;
            period_sh <= period;
            duty_sh   <= duty;
        end else if (at_end) begin
            cnt       <= '0;
            period_sh <= period;
            duty_sh   <= duty;
        end else begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/qar_timer_periph.sv
// Memory-mapped timer peripheral: prescaled compare timer with IRQ, keyed
// watchdog, synchronised input capture and one PWM channel.
module qar_timer_periph
    import qar_timer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter logic [31:0] WDT_KEY    = WDT_KEY_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    qar_timer_periph_if.slave  bus,
    input  logic               capture_in,
    output logic               pwm_out,
    output logic               irq_timer,
    output logic               wdt_reset_req
);

    logic                 ready_q;
    logic [31:0]          rdata_q;
    logic [7:0]           word_off;
    logic                 access;
    logic                 wr_en;
    logic                 wr_ctrl, wr_status, wr_prescale, wr_count, wr_compare;
    logic                 wr_wdt_load, wr_kick, wr_period, wr_duty;

    logic [CTRL_W-1:0]    ctrl;
    logic [ST_W-1:0]      status;
    logic [ST_W-1:0]      st_set;
    logic [ST_W-1:0]      st_clr;
    logic [CNT_WIDTH-1:0] prescale, pre_cnt, count, compare;
    logic [CNT_WIDTH-1:0] wdt_load, wdt_cnt, capture;
    logic [CNT_WIDTH-1:0] pwm_period, pwm_duty;

    logic                 tick;
    logic                 timer_hit;
    logic                 match_now;
    logic                 wdt_start;
    logic                 wdt_kick;
    logic                 wdt_expire;
    logic [2:0]           cap_sync;
    logic                 cap_rise;
    logic                 pwm_wrap;
    logic [31:0]          rd_mux;
    logic                 unused_addr_lsbs;

    assign unused_addr_lsbs = &{1'b0, bus.bus_addr[1:0]};

    assign word_off = 8'(bus.bus_addr[ADDR_WIDTH-1:2]);
    assign access   = bus.bus_valid & ~ready_q;
    assign wr_en    = access & bus.bus_we;

    assign wr_ctrl     = wr_en && (word_off == OFF_CTRL);
    assign wr_status   = wr_en && (word_off == OFF_STATUS);
    assign wr_prescale = wr_en && (word_off == OFF_PRESCALE);
    assign wr_count    = wr_en && (word_off == OFF_COUNT);
    assign wr_compare  = wr_en && (word_off == OFF_COMPARE);
    assign wr_wdt_load = wr_en && (word_off == OFF_WDT_LOAD);
    assign wr_kick     = wr_en && (word_off == OFF_WDT_KICK);
    assign wr_period   = wr_en && (word_off == OFF_PWM_PERIOD);
    assign wr_duty     = wr_en && (word_off == OFF_PWM_DUTY);

    assign tick       = (pre_cnt >= prescale);
    assign timer_hit  = tick & ctrl[CTRL_TMR_EN];
    assign match_now  = timer_hit & (count == compare);
    assign wdt_start  = wr_ctrl & bus.bus_wdata[CTRL_WDT_EN] & ~ctrl[CTRL_WDT_EN];
    assign wdt_kick   = wr_kick & (bus.bus_wdata == WDT_KEY);
    assign wdt_expire = tick & ctrl[CTRL_WDT_EN] & ~wdt_kick & (wdt_cnt == CNT_WIDTH'(1));
    assign cap_rise   = cap_sync[1] & ~cap_sync[2] & ctrl[CTRL_CAP_EN];
    assign st_clr     = wr_status ? bus.bus_wdata[ST_W-1:0] : '0;

    assign bus.bus_ready = ready_q;
    assign bus.bus_rdata = rdata_q;
    assign irq_timer     = status[ST_MATCH] & ctrl[CTRL_IRQ_EN];
    assign wdt_reset_req = status[ST_WDT_EXP];

    // Hardware events that set STATUS bits this cycle.
    always_comb begin
        st_set               = '0;
        st_set[ST_MATCH]     = match_now;
        st_set[ST_CAP_VALID] = cap_rise;
        st_set[ST_WDT_EXP]   = wdt_expire;
        st_set[ST_CAP_OVR]   = cap_rise & status[ST_CAP_VALID];
        st_set[ST_PWM_WRAP]  = pwm_wrap;
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux = '0;
        case (word_off)
            OFF_CTRL:       rd_mux = 32'(ctrl);
            OFF_STATUS:     rd_mux = 32'(status);
            OFF_PRESCALE:   rd_mux = 32'(prescale);
            OFF_COUNT:      rd_mux = 32'(count);
            OFF_COMPARE:    rd_mux = 32'(compare);
            OFF_WDT_LOAD:   rd_mux = 32'(wdt_load);
            OFF_CAPTURE:    rd_mux = 32'(capture);
            OFF_PWM_PERIOD: rd_mux = 32'(pwm_period);
            OFF_PWM_DUTY:   rd_mux = 32'(pwm_duty);
            default:        rd_mux = '0;
        endcase
    end

    // Bus handshake: one-cycle ready pulse, read data captured on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= access;
            rdata_q <= (access && !bus.bus_we) ? rd_mux : '0;
        end
    end

    // Software-owned configuration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl       <= '0;
            prescale   <= '0;
            compare    <= '0;
            wdt_load   <= '1;
            pwm_period <= '0;
            pwm_duty   <= '0;
        end else begin
            if (wr_ctrl)     ctrl       <= bus.bus_wdata[CTRL_W-1:0];
            if (wr_prescale) prescale   <= bus.bus_wdata[CNT_WIDTH-1:0];
            if (wr_compare)  compare    <= bus.bus_wdata[CNT_WIDTH-1:0];
            if (wr_wdt_load) wdt_load   <= bus.bus_wdata[CNT_WIDTH-1:0];
            if (wr_period)   pwm_period <= bus.bus_wdata[CNT_WIDTH-1:0];
            if (wr_duty)     pwm_duty   <= bus.bus_wdata[CNT_WIDTH-1:0];
        end
    end

    // Prescaler and compare timer; a software COUNT write beats a tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            count   <= '0;
        end else begin
            if (!ctrl[CTRL_TMR_EN] || tick) pre_cnt <= '0;
            else                            pre_cnt <= pre_cnt + CNT_WIDTH'(1);

            if (wr_count)       count <= bus.bus_wdata[CNT_WIDTH-1:0];
            else if (match_now) count <= '0;
            else if (timer_hit) count <= count + CNT_WIDTH'(1);
        end
    end

    // Watchdog down-counter: reload on enable or valid kick, stop at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdt_cnt <= '0;
        end else if (wdt_start || wdt_kick) begin
            wdt_cnt <= wdt_load;
        end else if (tick && ctrl[CTRL_WDT_EN] && (wdt_cnt != '0)) begin
            wdt_cnt <= wdt_cnt - CNT_WIDTH'(1);
        end
    end

    // Capture input synchroniser (two flops plus one for edge detect) and latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_sync <= '0;
            capture  <= '0;
        end else begin
            cap_sync <= {cap_sync[1:0], capture_in};
            if (cap_rise) capture <= count;
        end
    end

    // STATUS: write-one-to-clear, with a same-cycle hardware set taking priority.
    always_ff @(posedge clk) begin
        if (!rst_n) status <= '0;
        else        status <= (status & ~st_clr) | st_set;
    end

    qar_pwm_gen #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ctrl[CTRL_PWM_EN]),
        .period  (pwm_period),
        .duty    (pwm_duty),
        .pwm_out (pwm_out),
        .wrap    (pwm_wrap)
    );

endmodule
